// File: rtl/seg_pkg.sv
// seg_pkg: shared digit count, blank code and seven-segment patterns {g,f,e,d,c,b,a}
package seg_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111100;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1100111;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD code to segment pattern, codes above 9 decode to blank
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  // Table lookup over the shared segment constants
  always_comb
    seg_o = code_i == 4'd0 ? SEG_0 :
            code_i == 4'd1 ? SEG_1 :
            code_i == 4'd2 ? SEG_2 :
            code_i == 4'd3 ? SEG_3 :
            code_i == 4'd4 ? SEG_4 :
            code_i == 4'd5 ? SEG_5 :
            code_i == 4'd6 ? SEG_6 :
            code_i == 4'd7 ? SEG_7 :
            code_i == 4'd8 ? SEG_8 :
            code_i == 4'd9 ? SEG_9 : SEG_BLANK;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: six-digit multiplexed display scanner with frame capture, blink and blanking
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DWELL      = 1,
  parameter int BLINK_HALF = 250,
  parameter bit LZ_BLANK   = 1'b0
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] digit_4,
  input  logic [3:0] digit_5,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg,
  output logic [5:0] dig_sel,
  output logic       frame_start
);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  logic [2:0] idx_q;
  logic [DW-1:0] dwell_q;
  logic [BW-1:0] blink_q;
  logic blink_on_q;
  logic [NUM_DIGITS-1:0][3:0] shd_q;
  logic [NUM_DIGITS-1:0] msk_q;
  logic [6:0] seg_q;
  logic [5:0] dig_sel_q;
  logic frame_q;
  logic [NUM_DIGITS-1:0][3:0] dig_in;
  logic cap, dwell_wrap, blink_wrap, mask_bit, blank;
  logic [3:0] val;
  logic [6:0] seg_dec, seg_d;
  assign dig_in = {digit_5, digit_4, digit_3, digit_2, digit_1, digit_0};
  // Pick the current slot's code, bypassing the shadow on the capture cycle so slot 0 is never stale
  always_comb begin
    cap        = idx_q == 3'd0 && dwell_q == '0;
    dwell_wrap = dwell_q == DW'(DWELL - 1);
    blink_wrap = blink_q == BW'(BLINK_HALF - 1);
    val        = cap ? digit_0 : shd_q[idx_q];
    mask_bit   = cap ? blink_mask[0] : msk_q[idx_q];
    blank      = (mask_bit && !blink_on_q) || (LZ_BLANK && idx_q == 3'd5 && val == 4'd0);
    seg_d      = blank ? SEG_BLANK : seg_dec;
  end
  seg7_decode u_dec (
    .code_i (val),
    .seg_o  (seg_dec)
  );
  // Scan counters, blink divider, frame-aligned shadow capture and registered outputs
  always_ff @(posedge clk_1khz)
    if (!switch_clr) begin
      idx_q      <= '0;
      dwell_q    <= '0;
      blink_q    <= '0;
      blink_on_q <= 1'b1;
      shd_q      <= {NUM_DIGITS{BLANK_CODE}};
      msk_q      <= '0;
      seg_q      <= SEG_BLANK;
      dig_sel_q  <= '0;
      frame_q    <= 1'b0;
    end else begin
      dwell_q <= dwell_wrap ? '0 : dwell_q + 1'b1;
      if (dwell_wrap) idx_q <= idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
      blink_q <= blink_wrap ? '0 : blink_q + 1'b1;
      if (blink_wrap) blink_on_q <= !blink_on_q;
      if (cap) begin
        shd_q <= dig_in;
        msk_q <= blink_mask;
      end
      seg_q     <= seg_d;
      dig_sel_q <= 6'b000001 << idx_q;
      frame_q   <= cap;
    end
  assign seg = seg_q;
  assign dig_sel = dig_sel_q;
  assign frame_start = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized check of two scanner configurations against a frame-level model
module tb_seg_scan_driver;
  localparam int BH = 4;
  localparam int DW_T[2] = '{1, 3};
  localparam bit LZ_T[2] = '{1'b0, 1'b1};
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] dig[6];
  logic [5:0] mask;
  logic [6:0] seg_o[2];
  logic [5:0] sel_o[2];
  logic fs_o[2];
  int n_chk = 0, n_pass = 0;
  int n[2];
  logic [3:0] cap_dig[2][6];
  logic [5:0] cap_msk[2];
  logic [6:0] e_seg[2];
  logic [5:0] e_sel[2];
  logic e_fs[2];
  logic [6:0] seg_tab[16];
  always #5 clk = ~clk;
  seg_scan_driver #(.DWELL(1), .BLINK_HALF(BH), .LZ_BLANK(1'b0)) dut_a (
    .clk_1khz(clk), .switch_clr(rst_n),
    .digit_0(dig[0]), .digit_1(dig[1]), .digit_2(dig[2]),
    .digit_3(dig[3]), .digit_4(dig[4]), .digit_5(dig[5]),
    .blink_mask(mask), .seg(seg_o[0]), .dig_sel(sel_o[0]), .frame_start(fs_o[0])
  );
  seg_scan_driver #(.DWELL(3), .BLINK_HALF(BH), .LZ_BLANK(1'b1)) dut_b (
    .clk_1khz(clk), .switch_clr(rst_n),
    .digit_0(dig[0]), .digit_1(dig[1]), .digit_2(dig[2]),
    .digit_3(dig[3]), .digit_4(dig[4]), .digit_5(dig[5]),
    .blink_mask(mask), .seg(seg_o[1]), .dig_sel(sel_o[1]), .frame_start(fs_o[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  // Model: k edges after release, slot = (k/D)%6, frame boundary every 6D edges, blink phase = (k/BH)%2
  task automatic model();
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        n[u] = 0;
        e_seg[u] = 7'd0;
        e_sel[u] = 6'd0;
        e_fs[u] = 1'b0;
      end else begin
        int k, s;
        logic [3:0] v;
        logic on;
        k = n[u];
        if (k % (6 * DW_T[u]) == 0) begin
          for (int d = 0; d < 6; d++) cap_dig[u][d] = dig[d];
          cap_msk[u] = mask;
        end
        s = (k / DW_T[u]) % 6;
        v = cap_dig[u][s];
        on = ((k / BH) % 2) == 0;
        e_seg[u] = (cap_msk[u][s] && !on) || (LZ_T[u] && s == 5 && v == 4'd0) ? 7'd0 : seg_tab[v];
        e_sel[u] = 6'(1 << s);
        e_fs[u] = k % (6 * DW_T[u]) == 0;
        n[u] = k + 1;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("d%0d_seg", u), 32'(seg_o[u]), 32'(e_seg[u]));
      check($sformatf("d%0d_sel", u), 32'(sel_o[u]), 32'(e_sel[u]));
      check($sformatf("d%0d_fs", u), 32'(fs_o[u]), 32'(e_fs[u]));
    end
  endtask
  initial begin
    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111,
                7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    rst_n = 1'b0;
    mask = 6'd0;
    dig = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    repeat (3) step();
    rst_n = 1'b1;
    repeat (40) step();
    dig[2] = 4'hC;
    dig[3] = 4'd7;
    mask = 6'b001000;
    repeat (40) step();
    dig[5] = 4'd2;
    repeat (20) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (30) step();
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dig[5] = 4'd0;
      if ($urandom_range(0, 15) == 0) mask = 6'($urandom) & 6'($urandom);
      rst_n = $urandom_range(0, 149) != 0;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed six-digit seven-segment display driver: the receiving end of the BCD digit bus the clock core produces. Captures six 4-bit digit codes and a per-digit blink mask once per frame, scans them onto a shared segment bus with a one-hot digit strobe, and applies the 4 Hz-class blink and blank rules in hardware. It sits between the clock/alarm/stopwatch core and the board's multiplexed display, on the 1 kHz domain.

## Interface
Parameters:
- DWELL, 1: clk_1khz cycles each digit stays selected (≥1).
- BLINK_HALF, 250: cycles per blink half-period (250 → 2 Hz blink, 4 Hz toggle).
- LZ_BLANK, 0: 1 = blank digit 5 when its code is 0.

Ports (one clock; reset is synchronous and active-low):
- clk_1khz  in  1  sole clock, all state on rising edge.
- switch_clr  in  1  synchronous active-low reset.
- digit_0 … digit_5  in  4 each  BCD codes, digit_0 = seconds ones, digit_5 = hours tens; 4'hA–4'hF = blank.
- blink_mask  in  6  bit i = 1 → digit i blinks.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dig_sel  out  6  one-hot digit strobe, bit i = digit i, active-high.
- frame_start  out  1  one-cycle pulse, coincident with first dig_sel = 6'b000001 of each frame.

## Operation
- State: idx (0..5), dwell_cnt (0..DWELL-1), blink_cnt (0..BLINK_HALF-1), blink_on, shadow digits[6], shadow mask[6].
- Scan: every cycle dwell_cnt increments; at DWELL-1 it wraps to 0 and idx advances, 5 wraps to 0.
- Capture: when idx==0 && dwell_cnt==0, all six digits and blink_mask load into shadow. Mid-frame input changes are ignored until the next capture (no tearing).
- Blink: blink_cnt increments every cycle; at BLINK_HALF-1 it wraps and blink_on toggles.
- Output select for idx: value = shadow digit (bypass: at the capture cycle, digit_0/blink_mask[0] are used directly). Blank if value > 9, or (mask bit && !blink_on), or (LZ_BLANK && idx==5 && value==0).
- Encoding, fixed to match the core: 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110, 5→1101101, 6→1111100, 7→0000111, 8→1111111, 9→1100111, blank→0000000.
- Blanked digit: seg = 0, dig_sel still strobes (constant scan duty).

## Timing
- Reset (switch_clr low at an edge): seg=0, dig_sel=0, frame_start=0, idx=0, dwell_cnt=0, blink_cnt=0, blink_on=1, shadow digits=4'hF, shadow mask=0.
- Outputs are registered, one cycle behind (idx, dwell_cnt): first edge after reset release is the capture cycle; the next edge shows dig_sel=6'b000001, the digit_0 value at capture, frame_start=1.
- Digit i is held for DWELL cycles; frame = 6·DWELL cycles; frame_start period = 6·DWELL.
- Reset mid-frame: all state returns to reset values at that edge; the frame restarts cleanly after release.
- Blink toggle and capture on the same cycle: both take effect; the output uses the post-toggle blink_on from the next cycle.
- Inputs need setup only at capture edges; no handshake, no backpressure.

## Structure
- Shared package seg_pkg: NUM_DIGITS=6, BLANK_CODE=4'hF, SEG_BLANK=7'b0000000, the ten segment constants above. The clock core's decoder is re-pointed at the same constants.
- Sub-module seg7_decode: combinational 4-bit code → 7-bit segments, using seg_pkg; blank for codes >9.
- Top: scan/dwell counter, blink divider, shadow registers, output register.

## Test plan
- Sim with DWELL=1, BLINK_HALF=4.
- Reset then release with digits 1,2,3,4,5,0, mask 0 → dig_sel cycles 000001…100000; seg = 0000110, 1011011, 1001111, 1100110, 1101101, 0111111; frame_start every 6 cycles.
- Change digit_3 from 4 to 9 at the third cycle of a frame → current frame still shows 1100110 on dig_sel[3]; next frame shows 1100111.
- blink_mask=6'b001000, digit_3=7 → dig_sel[3] slot alternates 0000111 / 0000000 per 4-cycle blink half; other digits unaffected.
- digit_2=4'hC → seg=0 while dig_sel[2] is high; LZ_BLANK=1 with digit_5=0 → seg=0 in slot 5; digit_5=2 → 1011011.
- Assert switch_clr for one cycle mid-frame (idx=3) → next outputs seg=0, dig_sel=0; after release, frame restarts at dig_sel=000001 with frame_start=1; blink restarts visible.
- DWELL=3 → each dig_sel value held exactly 3 cycles; frame_start period 18.
